timer_ctrl: RTL and testbench

- Port-mapped controller that configures and sequences the 16-bit prescaled timer for the PicoBlaze system.
- Software writes mode, prescaler and reload registers over the CPU port bus; the block latches them onto the timer configuration inputs and issues `go` pulses.
- It detects expiries, supports one-shot and periodic auto-reload, counts expiries and raises a level interrupt with acknowledge handshake.
- It sits between the CPU I/O decode and the timer instance.

---
 rtl/timer_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_timer_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// CPU port-mapped controller that configures, restarts and monitors the 16-bit prescaled timer.
// Define TIMER_CTRL_EXPCNT_EN to include the 8-bit expiry counter register at BASE_ADDR+4.
module timer_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'h40
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  i_port_id,
    input  logic        i_write_strobe,
    input  logic        i_read_strobe,
    input  logic [7:0]  i_out_port,
    output logic [7:0]  o_in_port,
    output logic        o_interrupt,
    input  logic        i_interrupt_ack,
    output logic [2:0]  o_prescaler_conf,
    output logic [15:0] o_timer_conf,
    output logic        o_go,
    input  logic        i_tmr_int
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [7:0]  r_ctrl;
    logic [7:0]  r_loadLo;
    logic [15:0] r_load;
    logic        r_exp;
    logic        r_ovr;
    logic        r_interrupt;
    logic        r_tmrPrev;
    logic        r_go;
    logic [2:0]  r_prescalerConf;
    logic [15:0] r_timerConf;
    logic [7:0]  r_inPort;

    logic [7:0]  w_offset;
    logic        w_wrCtrl;
    logic        w_wrLoadLo;
    logic        w_wrLoadHi;
    logic        w_wrStatus;
    logic        w_tmrEdge;
    logic        w_expiry;
    logic        w_enEff;
    logic        w_running;
    logic [7:0]  w_readData;
    logic        w_unusedRead;

    // Reads have no side effects, so the read qualifier is not needed.
    assign w_unusedRead = i_read_strobe;

    assign w_offset   = i_port_id - BASE_ADDR;
    assign w_wrCtrl   = i_write_strobe && (w_offset == 8'd0);
    assign w_wrLoadLo = i_write_strobe && (w_offset == 8'd1);
    assign w_wrLoadHi = i_write_strobe && (w_offset == 8'd2);
    assign w_wrStatus = i_write_strobe && (w_offset == 8'd3);

    assign w_tmrEdge  = i_tmr_int && !r_tmrPrev;
    assign w_expiry   = (r_state == RUN) && w_tmrEdge;
    assign w_running  = (r_state != IDLE);
    // A CTRL write landing with an expiry must be able to stop a periodic restart.
    assign w_enEff    = w_wrCtrl ? i_out_port[0] : r_ctrl[0];

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (r_ctrl[0] && (r_load != 16'd0)) begin
                    w_nextState = START;
                end
            end
            START: w_nextState = RUN;
            RUN: begin
                if (!w_enEff) begin
                    w_nextState = IDLE;
                end else if (w_expiry) begin
                    w_nextState = r_ctrl[1] ? START : DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state         <= IDLE;
            r_go            <= 1'b0;
            r_prescalerConf <= 3'd0;
            r_timerConf     <= 16'd0;
            r_tmrPrev       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_go    <= (w_nextState == START);
            // Timer configuration only changes on entry to START so it is stable during RUN.
            if (w_nextState == START) begin
                r_prescalerConf <= r_ctrl[6:4];
                r_timerConf     <= r_load;
            end
            r_tmrPrev <= (r_state == START) ? 1'b0 : i_tmr_int;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_ctrl      <= 8'd0;
            r_loadLo    <= 8'd0;
            r_load      <= 16'd0;
            r_exp       <= 1'b0;
            r_ovr       <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            if (w_wrCtrl) begin
                r_ctrl <= i_out_port & 8'h77;
            end
            if (w_expiry && !r_ctrl[1]) begin
                r_ctrl[0] <= 1'b0;
            end
            if (w_wrLoadLo) begin
                r_loadLo <= i_out_port;
            end
            if (w_wrLoadHi) begin
                r_load <= {i_out_port, r_loadLo};
            end
            // Clears come first so a coincident expiry keeps its flags set.
            if (w_wrStatus && i_out_port[0]) begin
                r_exp <= 1'b0;
            end
            if (w_wrStatus && i_out_port[2]) begin
                r_ovr <= 1'b0;
            end
            if (i_interrupt_ack || (w_wrStatus && i_out_port[0])) begin
                r_interrupt <= 1'b0;
            end
            if (w_expiry) begin
                r_exp <= 1'b1;
                if (r_exp) begin
                    r_ovr <= 1'b1;
                end
                if (r_ctrl[2]) begin
                    r_interrupt <= 1'b1;
                end
            end
        end
    end

`ifdef TIMER_CTRL_EXPCNT_EN
    logic [7:0] r_expCnt;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_expCnt <= 8'd0;
        end else if (w_expiry) begin
            r_expCnt <= r_expCnt + 8'd1;
        end
    end
`endif

    always_comb begin
        w_readData = 8'h00;
        case (w_offset)
            8'd0: w_readData = r_ctrl;
            8'd1: w_readData = r_loadLo;
            8'd2: w_readData = r_load[15:8];
            8'd3: w_readData = {5'd0, r_ovr, w_running, r_exp};
`ifdef TIMER_CTRL_EXPCNT_EN
            8'd4: w_readData = r_expCnt;
`endif
            default: w_readData = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_inPort <= 8'd0;
        end else begin
            r_inPort <= w_readData;
        end
    end

    assign o_in_port        = r_inPort;
    assign o_interrupt      = r_interrupt;
    assign o_prescaler_conf = r_prescalerConf;
    assign o_timer_conf     = r_timerConf;
    assign o_go             = r_go;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: expected reads and go pulses are queued when driven, compared when seen.
// Expected EXPCNT values follow TIMER_CTRL_EXPCNT_EN the same way the design does.
module tb_timer_ctrl;

    localparam logic [7:0] BASE = 8'h40;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [7:0]  i_port_id;
    logic        i_write_strobe;
    logic        i_read_strobe;
    logic [7:0]  i_out_port;
    logic [7:0]  o_in_port;
    logic        o_interrupt;
    logic        i_interrupt_ack;
    logic [2:0]  o_prescaler_conf;
    logic [15:0] o_timer_conf;
    logic        o_go;
    logic        i_tmr_int;

    int checkCount = 0;
    int errCount   = 0;

    logic [18:0] goQ[$];
    logic [7:0]  rdExpQ[$];
    string       rdTagQ[$];
    logic        rdReq = 1'b0;
    logic        rdSample;
    logic [18:0] goExp;

    logic        mExp = 1'b0;
    logic        mOvr = 1'b0;
    logic        mInt = 1'b0;
    logic        mIe  = 1'b0;
    logic [7:0]  mCnt = 8'd0;

    timer_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk_in           (clk_in),
        .rst              (rst),
        .i_port_id        (i_port_id),
        .i_write_strobe   (i_write_strobe),
        .i_read_strobe    (i_read_strobe),
        .i_out_port       (i_out_port),
        .o_in_port        (o_in_port),
        .o_interrupt      (o_interrupt),
        .i_interrupt_ack  (i_interrupt_ack),
        .o_prescaler_conf (o_prescaler_conf),
        .o_timer_conf     (o_timer_conf),
        .o_go             (o_go),
        .i_tmr_int        (i_tmr_int)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] off, input logic [7:0] data,
                                 input logic tmr, input logic ack);
        i_port_id       = BASE + off;
        i_out_port      = data;
        i_write_strobe  = wr;
        i_tmr_int       = tmr;
        i_interrupt_ack = ack;
        @(negedge clk_in);
        i_write_strobe  = 1'b0;
        i_tmr_int       = 1'b0;
        i_interrupt_ack = 1'b0;
    endtask

    task automatic writeReg(input logic [7:0] off, input logic [7:0] data);
        applyStimulus(1'b1, off, data, 1'b0, 1'b0);
    endtask

    task automatic pulseTmr();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic ackInt();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic readReg(input logic [7:0] off, input logic [7:0] expected, input string tag);
        i_port_id     = BASE + off;
        i_read_strobe = 1'b1;
        rdReq         = 1'b1;
        rdExpQ.push_back(expected);
        rdTagQ.push_back(tag);
        @(negedge clk_in);
        i_read_strobe = 1'b0;
        rdReq         = 1'b0;
    endtask

    task automatic modelExpiry();
        if (mExp) mOvr = 1'b1;
        mExp = 1'b1;
        if (mIe) mInt = 1'b1;
        mCnt = mCnt + 8'd1;
    endtask

    task automatic modelStatusWr(input logic [7:0] d);
        if (d[0]) begin
            mExp = 1'b0;
            mInt = 1'b0;
        end
        if (d[2]) mOvr = 1'b0;
    endtask

    function automatic logic [7:0] statusExp(input logic run);
        return {5'd0, mOvr, run, mExp};
    endfunction

    function automatic logic [7:0] cntExp();
`ifdef TIMER_CTRL_EXPCNT_EN
        return mCnt;
`else
        return 8'h00;
`endif
    endfunction

    // Read data appears one clock after the address, so pop on the edge following a read request.
    always @(posedge clk_in) begin
        rdSample = rdReq;
        #1;
        if (rdSample) begin
            if (rdExpQ.size() == 0) begin
                checkOutput("read underflow", 1, 0);
            end else begin
                checkOutput(rdTagQ.pop_front(), 32'(o_in_port), 32'(rdExpQ.pop_front()));
            end
        end
    end

    always @(posedge clk_in) begin
        #1;
        if (o_go === 1'b1) begin
            if (goQ.size() == 0) begin
                checkOutput("go unexpected", 1, 0);
            end else begin
                goExp = goQ.pop_front();
                checkOutput("go conf", 32'({o_prescaler_conf, o_timer_conf}), 32'(goExp));
            end
        end
    end

    initial begin
        rst             = 1'b1;
        i_port_id       = 8'h00;
        i_write_strobe  = 1'b0;
        i_read_strobe   = 1'b0;
        i_out_port      = 8'h00;
        i_interrupt_ack = 1'b0;
        i_tmr_int       = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        checkOutput("reset go", 32'(o_go), 0);
        checkOutput("reset int", 32'(o_interrupt), 0);
        checkOutput("reset presc", 32'(o_prescaler_conf), 0);
        checkOutput("reset conf", 32'(o_timer_conf), 0);
        for (int i = 0; i < 6; i++) readReg(8'(i), 8'h00, "reset read");

        // One-shot with interrupt enabled
        writeReg(8'd1, 8'h10);
        writeReg(8'd2, 8'h00);
        readReg(8'd1, 8'h10, "load lo");
        readReg(8'd2, 8'h00, "load hi");
        mIe = 1'b1;
        goQ.push_back({3'd3, 16'h0010});
        writeReg(8'd0, 8'h35);
        checkOutput("go cycle1", 32'(o_go), 0);
        tick(1);
        checkOutput("go latency", 32'(o_go), 1);
        checkOutput("go presc", 32'(o_prescaler_conf), 3);
        checkOutput("go conf direct", 32'(o_timer_conf), 32'h0010);
        tick(2);
        readReg(8'd3, statusExp(1'b1), "status run");
        pulseTmr();
        modelExpiry();
        checkOutput("int oneshot", 32'(o_interrupt), 32'(mInt));
        tick(1);
        readReg(8'd3, statusExp(1'b0), "status oneshot");
        readReg(8'd0, 8'h34, "ctrl en cleared");
        readReg(8'd4, cntExp(), "expcnt one");
        ackInt();
        mInt = 1'b0;
        checkOutput("int ack", 32'(o_interrupt), 0);
        writeReg(8'd3, 8'h05);
        modelStatusWr(8'h05);
        readReg(8'd3, statusExp(1'b0), "status cleared");

        // Periodic with interrupt disabled
        mIe = 1'b0;
        goQ.push_back({3'd0, 16'h0010});
        writeReg(8'd0, 8'h03);
        tick(4);
        for (int i = 0; i < 3; i++) begin
            goQ.push_back({3'd0, 16'h0010});
            pulseTmr();
            modelExpiry();
            tick(3);
        end
        readReg(8'd3, statusExp(1'b1), "status periodic");
        checkOutput("int masked", 32'(o_interrupt), 0);
        readReg(8'd4, cntExp(), "expcnt periodic");

        // EXP W1C coincident with an expiry
        goQ.push_back({3'd0, 16'h0010});
        applyStimulus(1'b1, 8'd3, 8'h01, 1'b1, 1'b0);
        modelStatusWr(8'h01);
        modelExpiry();
        tick(3);
        readReg(8'd3, statusExp(1'b1), "exp set wins");

        // Acknowledge coincident with an expiry
        writeReg(8'd0, 8'h07);
        mIe = 1'b1;
        writeReg(8'd3, 8'h05);
        modelStatusWr(8'h05);
        readReg(8'd3, statusExp(1'b1), "status clear2");
        goQ.push_back({3'd0, 16'h0010});
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        mInt = 1'b0;
        modelExpiry();
        checkOutput("int set wins", 32'(o_interrupt), 32'(mInt));
        tick(3);
        ackInt();
        mInt = 1'b0;
        checkOutput("int ack2", 32'(o_interrupt), 0);

        // STATUS write clearing EXP also drops the interrupt
        goQ.push_back({3'd0, 16'h0010});
        pulseTmr();
        modelExpiry();
        checkOutput("int set", 32'(o_interrupt), 32'(mInt));
        tick(3);
        writeReg(8'd3, 8'h01);
        modelStatusWr(8'h01);
        checkOutput("int w1c", 32'(o_interrupt), 32'(mInt));
        readReg(8'd3, statusExp(1'b1), "status w1c exp");

        // Clearing IE leaves a pending interrupt
        goQ.push_back({3'd0, 16'h0010});
        pulseTmr();
        modelExpiry();
        tick(3);
        writeReg(8'd0, 8'h03);
        mIe = 1'b0;
        checkOutput("int ie off", 32'(o_interrupt), 32'(mInt));
        ackInt();
        mInt = 1'b0;
        checkOutput("int ack3", 32'(o_interrupt), 0);
        readReg(8'd3, statusExp(1'b1), "status ovr");
        writeReg(8'd3, 8'h05);
        modelStatusWr(8'h05);

        // Reconfiguration while running waits for the next START
        writeReg(8'd0, 8'h53);
        writeReg(8'd1, 8'h34);
        writeReg(8'd2, 8'h12);
        tick(1);
        checkOutput("presc hold", 32'(o_prescaler_conf), 0);
        checkOutput("conf hold", 32'(o_timer_conf), 32'h0010);
        goQ.push_back({3'd5, 16'h1234});
        pulseTmr();
        modelExpiry();
        tick(3);
        checkOutput("conf reload", 32'(o_timer_conf), 32'h1234);
        checkOutput("presc reload", 32'(o_prescaler_conf), 5);

        // EN cleared in the same cycle as an expiry: recorded, no restart
        applyStimulus(1'b1, 8'd0, 8'h52, 1'b1, 1'b0);
        modelExpiry();
        tick(3);
        readReg(8'd3, statusExp(1'b0), "en off expiry");
        readReg(8'd4, cntExp(), "expcnt en off");
        readReg(8'd0, 8'h52, "ctrl en off");

        // Reset in the middle of a run
        mIe = 1'b1;
        goQ.push_back({3'd5, 16'h1234});
        writeReg(8'd0, 8'h57);
        tick(4);
        goQ.push_back({3'd5, 16'h1234});
        pulseTmr();
        modelExpiry();
        tick(1);
        checkOutput("int before rst", 32'(o_interrupt), 32'(mInt));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mExp = 1'b0; mOvr = 1'b0; mInt = 1'b0; mIe = 1'b0; mCnt = 8'd0;
        checkOutput("rst go", 32'(o_go), 0);
        checkOutput("rst int", 32'(o_interrupt), 0);
        checkOutput("rst presc", 32'(o_prescaler_conf), 0);
        checkOutput("rst conf", 32'(o_timer_conf), 0);
        tick(5);
        for (int i = 0; i < 5; i++) readReg(8'(i), 8'h00, "rst read");

        // Expiry counter wrap
        writeReg(8'd1, 8'h01);
        writeReg(8'd2, 8'h00);
        goQ.push_back({3'd0, 16'h0001});
        writeReg(8'd0, 8'h03);
        tick(4);
        for (int i = 0; i < 255; i++) begin
            goQ.push_back({3'd0, 16'h0001});
            pulseTmr();
            modelExpiry();
            tick(2);
        end
        readReg(8'd4, cntExp(), "expcnt ff");
        goQ.push_back({3'd0, 16'h0001});
        pulseTmr();
        modelExpiry();
        tick(2);
        readReg(8'd4, cntExp(), "expcnt wrap");
        writeReg(8'd0, 8'h00);
        tick(4);
        checkOutput("go pending", goQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
